// File: rtl/memory_board_ctrl_pkg.sv
// memory_pkg: shared enums and the cursor wrap helper for the memory board controller
package memory_pkg;
  typedef enum logic [1:0] {HIDDEN, SHOWN, MATCHED} cell_state_t;
  typedef enum logic [1:0] {DIR_RIGHT, DIR_LEFT, DIR_DOWN, DIR_UP} dir_t;
  typedef enum logic [2:0] {PICK1, PICK2, COMPARE, SHOW_MISS, DONE} fsm_t;
  function automatic int wrap(input int v, input int lim, input logic inc);
    return inc ? (v == lim - 1 ? 0 : v + 1) : (v == 0 ? lim - 1 : v - 1);
  endfunction
endpackage

// File: rtl/memory_board_ctrl_edge_pulse.sv
// edge_pulse: rising-edge detector; pulse is high while sig is high and was low last cycle
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);
  logic prev;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else prev <= sig;
  end
  assign pulse = sig & ~prev;
endmodule

// File: rtl/memory_board_ctrl.sv
// memory_board_ctrl: cursor, pick/compare FSM and per-cell state for a concentration board
module memory_board_ctrl
  import memory_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int CELL_W = 4,
  parameter int CNT_W = 8,
  parameter int REVEAL_CYCLES = 4,
  localparam int N = ROWS * COLS,
  localparam int IDX_W = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [N*CELL_W-1:0] card_vals,
  input  logic                move,
  input  logic [1:0]          dir,
  input  logic                select,
  output logic [IDX_W-1:0]    cursor,
  output logic [2*N-1:0]      cell_state,
  output logic [N*CELL_W-1:0] cell_val,
  output logic [CNT_W-1:0]    attempts,
  output logic [IDX_W-1:0]    pairs,
  output logic                busy,
  output logic                done
);
  localparam int TW = $clog2(REVEAL_CYCLES + 1);
  fsm_t state, state_n;
  cell_state_t cells [N];
  logic [CELL_W-1:0] vals [N];
  logic [IDX_W-1:0] first, second, cur_n;
  logic [TW-1:0] timer;
  logic mv_ev, sel_ev, pick_ok, eq, last_pair;
  dir_t d;
  int r, c;

  edge_pulse u_move (.clk(clk), .rst(rst), .sig(move), .pulse(mv_ev));
  edge_pulse u_select (.clk(clk), .rst(rst), .sig(select), .pulse(sel_ev));

  assign d = dir_t'(dir);
  assign pick_ok = sel_ev && cells[cursor] == HIDDEN;
  assign eq = vals[first] == vals[second];
  assign last_pair = pairs == IDX_W'(N / 2 - 1);

  always_comb begin
    r = int'(cursor) / COLS;
    c = int'(cursor) % COLS;
    r = (d == DIR_DOWN || d == DIR_UP) ? wrap(r, ROWS, d == DIR_DOWN) : r;
    c = (d == DIR_RIGHT || d == DIR_LEFT) ? wrap(c, COLS, d == DIR_RIGHT) : c;
    cur_n = IDX_W'(r * COLS + c);
  end

  always_comb begin
    state_n = state;
    case (state)
      PICK1:     state_n = pick_ok ? PICK2 : PICK1;
      PICK2:     state_n = pick_ok ? COMPARE : PICK2;
      COMPARE:   state_n = !eq ? SHOW_MISS : last_pair ? DONE : PICK1;
      SHOW_MISS: state_n = timer == TW'(1) ? PICK1 : SHOW_MISS;
      default:   state_n = state;
    endcase
    if (load) state_n = PICK1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PICK1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      busy <= state_n == COMPARE || state_n == SHOW_MISS;
      done <= state_n == DONE;
    end
  end

  // the first pick cannot be re-picked in PICK2 because it is no longer HIDDEN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        cells[i] <= HIDDEN;
        vals[i] <= '0;
      end
      cursor <= '0;
      first <= '0;
      second <= '0;
      attempts <= '0;
      pairs <= '0;
      timer <= '0;
    end else if (load) begin
      for (int i = 0; i < N; i++) begin
        cells[i] <= HIDDEN;
        vals[i] <= card_vals[i*CELL_W +: CELL_W];
      end
      cursor <= '0;
      attempts <= '0;
      pairs <= '0;
      timer <= '0;
    end else begin
      if (mv_ev && state != DONE) cursor <= cur_n;
      if (pick_ok && state == PICK1) begin
        cells[cursor] <= SHOWN;
        first <= cursor;
      end
      if (pick_ok && state == PICK2) begin
        cells[cursor] <= SHOWN;
        second <= cursor;
      end
      if (state == COMPARE) begin
        attempts <= (&attempts) ? attempts : attempts + CNT_W'(1);
        if (eq) begin
          cells[first] <= MATCHED;
          cells[second] <= MATCHED;
          pairs <= pairs + IDX_W'(1);
        end else timer <= TW'(REVEAL_CYCLES);
      end
      if (state == SHOW_MISS) begin
        timer <= timer - TW'(1);
        if (timer == TW'(1)) begin
          cells[first] <= HIDDEN;
          cells[second] <= HIDDEN;
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_out
    assign cell_state[2*g +: 2] = cells[g];
    assign cell_val[g*CELL_W +: CELL_W] = vals[g];
  end
endmodule

// File: tb/tb_memory_board_ctrl.sv
// tb_memory_board_ctrl: randomized and directed stimulus against a queue-based board model
module tb_memory_board_ctrl;
  localparam int ROWS = 4, COLS = 4, CELL_W = 4, CNT_W = 8, RC = 4;
  localparam int N = ROWS * COLS, IDX_W = 4;
  logic clk = 0, rst, load, move, select;
  logic [1:0] dir;
  logic [N*CELL_W-1:0] card_vals;
  logic [IDX_W-1:0] cursor, pairs;
  logic [2*N-1:0] cell_state;
  logic [N*CELL_W-1:0] cell_val;
  logic [CNT_W-1:0] attempts;
  logic busy, done;

  memory_board_ctrl #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .CNT_W(CNT_W), .REVEAL_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .load(load), .card_vals(card_vals), .move(move), .dir(dir),
    .select(select), .cursor(cursor), .cell_state(cell_state), .cell_val(cell_val),
    .attempts(attempts), .pairs(pairs), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cur; logic [2*N-1:0] st; logic [N*CELL_W-1:0] val; int att; int prs; bit bsy; bit dn;
  } snap_t;
  snap_t exp_q[$];
  int checks = 0, failures = 0;

  int m_cell[N], m_val[N], picked[$];
  int m_row, m_col, m_att, m_pairs, m_hide;
  bit m_cmp, m_done, pm, ps;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, got, expv);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin m_cell[i] = 0; m_val[i] = 0; end
    picked.delete();
    m_row = 0; m_col = 0; m_att = 0; m_pairs = 0; m_hide = 0;
    m_cmp = 0; m_done = 0; pm = 0; ps = 0;
  endfunction

  function automatic void m_step(input bit ld, input bit mv_in, input int d, input bit sl_in,
                                 input logic [N*CELL_W-1:0] cv);
    bit mv, sl;
    int cur;
    mv = mv_in && !pm;
    sl = sl_in && !ps;
    pm = mv_in;
    ps = sl_in;
    if (ld) begin
      for (int i = 0; i < N; i++) begin m_cell[i] = 0; m_val[i] = int'(cv[i*CELL_W +: CELL_W]); end
      picked.delete();
      m_row = 0; m_col = 0; m_att = 0; m_pairs = 0; m_hide = 0; m_cmp = 0; m_done = 0;
      return;
    end
    if (m_done) return;
    cur = m_row * COLS + m_col;
    if (m_cmp) begin
      m_cmp = 0;
      if (m_att < 2**CNT_W - 1) m_att++;
      if (m_val[picked[0]] == m_val[picked[1]]) begin
        m_cell[picked[0]] = 2;
        m_cell[picked[1]] = 2;
        picked.delete();
        m_pairs++;
        if (m_pairs == N / 2) m_done = 1;
      end else m_hide = RC;
    end else if (m_hide > 0) begin
      m_hide--;
      if (m_hide == 0) begin
        foreach (picked[k]) m_cell[picked[k]] = 0;
        picked.delete();
      end
    end else if (sl && m_cell[cur] == 0) begin
      m_cell[cur] = 1;
      picked.push_back(cur);
      if (picked.size() == 2) m_cmp = 1;
    end
    if (mv) begin
      if (d == 0) m_col = (m_col + 1) % COLS;
      if (d == 1) m_col = (m_col + COLS - 1) % COLS;
      if (d == 2) m_row = (m_row + 1) % ROWS;
      if (d == 3) m_row = (m_row + ROWS - 1) % ROWS;
    end
  endfunction

  function automatic snap_t m_snap();
    snap_t s;
    s.cur = m_row * COLS + m_col;
    for (int i = 0; i < N; i++) begin
      s.st[2*i +: 2] = 2'(m_cell[i]);
      s.val[i*CELL_W +: CELL_W] = CELL_W'(m_val[i]);
    end
    s.att = m_att; s.prs = m_pairs; s.bsy = m_cmp || m_hide > 0; s.dn = m_done;
    return s;
  endfunction

  task automatic step(input bit ld, input bit mv, input int d, input bit sl);
    @(negedge clk);
    load = ld; move = mv; dir = 2'(d); select = sl;
    m_step(ld, mv, d, sl, card_vals);
    exp_q.push_back(m_snap());
  endtask

  task automatic idle(input int n); repeat (n) step(0, 0, 0, 0); endtask
  task automatic mv(input int d); step(0, 1, d, 0); step(0, 0, d, 0); endtask
  task automatic sel(); step(0, 0, 0, 1); step(0, 0, 0, 0); endtask

  task automatic goto(input int target);
    int guard = 0;
    while (m_row * COLS + m_col != target && guard < 2 * N) begin mv(0); guard++; end
  endtask

  task automatic load_pairs();
    for (int i = 0; i < N; i++) card_vals[i*CELL_W +: CELL_W] = CELL_W'(i / 2);
    step(1, 0, 0, 0);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_cursor"}, 64'(cursor), 0);
    check({tag, "_cell_state"}, 64'(cell_state), 0);
    check({tag, "_cell_val"}, 64'(cell_val), 0);
    check({tag, "_attempts"}, 64'(attempts), 0);
    check({tag, "_pairs"}, 64'(pairs), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
  endtask

  initial begin : monitor
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cursor", 64'(cursor), 64'(e.cur));
        check("cell_state", 64'(cell_state), 64'(e.st));
        check("cell_val", 64'(cell_val), 64'(e.val));
        check("attempts", 64'(attempts), 64'(e.att));
        check("pairs", 64'(pairs), 64'(e.prs));
        check("busy", 64'(busy), 64'(e.bsy));
        check("done", 64'(done), 64'(e.dn));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: run did not complete within time budget");
    $fatal(1);
  end

  initial begin : driver
    rst = 1; load = 0; move = 0; select = 0; dir = 0; card_vals = '0;
    #12;
    chk_reset("reset");
    m_reset();
    @(negedge clk);
    rst = 0;
    load_pairs();
    idle(1);
    repeat (3) step(0, 1, 0, 0);
    idle(1);
    mv(0); mv(0); mv(0);
    mv(3); mv(2);
    sel(); mv(0); sel(); idle(3);
    mv(0); sel(); mv(0); mv(0); sel(); idle(2); sel(); idle(6);
    repeat (4) mv(1);
    sel();
    goto(5);
    step(0, 1, 0, 1); step(0, 0, 0, 0);
    mv(1); sel(); mv(0); sel(); idle(RC + 3);
    repeat (800) begin
      if ($urandom_range(0, 99) == 0) begin
        for (int i = 0; i < N; i++) card_vals[i*CELL_W +: CELL_W] = CELL_W'($urandom_range(0, 3));
        step(1, 0, 0, 0);
      end else step(0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    end
    idle(RC + 3);
    load_pairs();
    for (int k = 0; k < N / 2; k++) begin goto(2 * k); sel(); mv(0); sel(); idle(2); end
    idle(1); mv(0); sel(); mv(2); idle(2);
    step(1, 0, 0, 0); idle(2);
    load_pairs();
    sel(); mv(0); mv(0); sel(); idle(3);
    @(negedge clk);
    #2;
    rst = 1; load = 0; move = 0; select = 0;
    #1;
    chk_reset("async_rst");
    m_reset();
    @(negedge clk);
    rst = 0;
    load_pairs();
    mv(0);
    repeat (2**CNT_W + 1) begin sel(); mv(0); sel(); idle(RC + 2); mv(1); end
    idle(3);
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
